// File: rtl/dff_bank_arbiter_if.sv
// Bus bundle for dff_bank_arbiter: requester write handshake plus the shared read port.
interface dff_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    localparam int GRANT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] wr_addr;
    logic [NREQ*WIDTH-1:0]  wr_data;
    logic [NREQ-1:0]        ack;
    logic                   busy;
    logic [GRANT_W-1:0]     grant_id;
    logic [ADDR_W-1:0]      rd_addr;
    logic [WIDTH-1:0]       rd_data;

    modport master (
        output req, wr_addr, wr_data, rd_addr,
        input  ack, busy, grant_id, rd_data
    );

    modport slave (
        input  req, wr_addr, wr_data, rd_addr,
        output ack, busy, grant_id, rd_data
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Register bank with a round-robin arbitrated write port and a combinational read port.
// Define DFF_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module dff_bank_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    dff_bank_arbiter_if.slave  bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int GRANT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NREQ-1:0]    ack_r;
    logic [NREQ-1:0]    ack_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic [GRANT_W-1:0] grant_r;
    logic [GRANT_W-1:0] grant_nxt_s;
    logic [GRANT_W-1:0] winner_s;
    logic [ADDR_W-1:0]  waddr_s;
    logic [WIDTH-1:0]   wdata_s;
    logic [WIDTH-1:0]   bank_r [DEPTH];

`ifdef DFF_ARB_FIXED_PRI_EN
    // Fixed priority: scanning downward leaves the lowest asserted index as winner.
    always_comb begin
        winner_s = {GRANT_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                winner_s = GRANT_W'(i);
            end else begin
                winner_s = winner_s;
            end
        end
    end
`else
    logic [GRANT_W-1:0] ptr_r;
    logic [GRANT_W-1:0] idx_s;
    int                 sum_s;

    // Round-robin: scan offsets downward so the nearest request at/after the pointer wins.
    always_comb begin
        winner_s = {GRANT_W{1'b0}};
        idx_s    = {GRANT_W{1'b0}};
        sum_s    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_s = int'(ptr_r) + k;
            if (sum_s >= NREQ) begin
                sum_s = sum_s - NREQ;
            end else begin
                sum_s = sum_s;
            end
            idx_s = GRANT_W'(sum_s);
            if (bus.req[idx_s]) begin
                winner_s = idx_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Pointer advances past the requester whose write completes this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {GRANT_W{1'b0}};
        end else if (state_r == WRITE) begin
            ptr_r <= (grant_r == GRANT_W'(NREQ - 1)) ? {GRANT_W{1'b0}} : grant_r + GRANT_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Next-state and registered-output decode for the IDLE/WRITE handshake.
    always_comb begin
        state_nxt_s = state_r;
        ack_nxt_s   = {NREQ{1'b0}};
        busy_nxt_s  = 1'b0;
        grant_nxt_s = grant_r;
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt_s = WRITE;
                    ack_nxt_s   = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
                    busy_nxt_s  = 1'b1;
                    grant_nxt_s = winner_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ack_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            grant_r <= {GRANT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= ack_nxt_s;
            busy_r  <= busy_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Address/data of the granted requester, sampled during the WRITE cycle.
    always_comb begin
        waddr_s = {ADDR_W{1'b0}};
        wdata_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (grant_r == GRANT_W'(i)) begin
                waddr_s = bus.wr_addr[i*ADDR_W +: ADDR_W];
                wdata_s = bus.wr_data[i*WIDTH +: WIDTH];
            end else begin
                waddr_s = waddr_s;
                wdata_s = wdata_s;
            end
        end
    end

    // Register bank; reset wins over an in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                bank_r[d] <= {WIDTH{1'b0}};
            end
        end else if (state_r == WRITE) begin
            bank_r[waddr_s] <= wdata_s;
        end else begin
            bank_r[waddr_s] <= bank_r[waddr_s];
        end
    end

    assign bus.ack      = ack_r;
    assign bus.busy     = busy_r;
    assign bus.grant_id = grant_r;
    assign bus.rd_data  = bank_r[bus.rd_addr];
endmodule
